// File: rtl/cp1_fpu.sv
// cp1_fpu: MIPS COP1 register file with moves, sign ops and compares,
// plus an iterative single-precision add/sub (one shift per cycle).
module cp1_fpu #(
    parameter int ALIGN_MAX = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic [31:0] data_to_cp1,
    output logic [31:0] data_from_cp1,
    output logic        cond,
    output logic        busy,
    output logic        done
);
    localparam int            CW    = $clog2(ALIGN_MAX + 1);
    localparam logic [7:0]    AMAX8 = 8'(ALIGN_MAX);
    localparam logic [CW-1:0] AMAXC = CW'(ALIGN_MAX);

    localparam logic [5:0] OP_COP1 = 6'b010001;
    localparam logic [4:0] FMT_MF  = 5'b00000;
    localparam logic [4:0] FMT_MT  = 5'b00100;
    localparam logic [4:0] FMT_S   = 5'b10000;
    localparam logic [5:0] F_ADD   = 6'b000000;
    localparam logic [5:0] F_SUB   = 6'b000001;
    localparam logic [5:0] F_ABS   = 6'b000101;
    localparam logic [5:0] F_MOV   = 6'b000110;
    localparam logic [5:0] F_NEG   = 6'b000111;
    localparam logic [5:0] F_CEQ   = 6'b110010;
    localparam logic [5:0] F_CLT   = 6'b111100;
    localparam logic [5:0] F_CLE   = 6'b111110;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_WRITE
    } state_e;

    state_e state_q, state_d;

    logic [31:0] fpr_q [32];
    logic        cond_q, cond_d;

    logic [31:0]       opa_q, opa_d;
    logic [31:0]       opb_q, opb_d;
    logic [4:0]        fd_q, fd_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic [23:0]       ma_q, ma_d;
    logic [23:0]       mb_q, mb_d;
    logic signed [9:0] exp_q, exp_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              big_q, big_d;

    logic        is_cp1, is_mf, is_mt, is_s, issue;
    logic [4:0]  fmt, ft, fs, fd;
    logic [5:0]  funct;
    logic [31:0] fs_v, ft_v;

    assign is_cp1 = inst[31:26] == OP_COP1;
    assign fmt    = inst[25:21];
    assign ft     = inst[20:16];
    assign fs     = inst[15:11];
    assign fd     = inst[10:6];
    assign funct  = inst[5:0];
    assign is_mf  = is_cp1 && fmt == FMT_MF;
    assign is_mt  = is_cp1 && fmt == FMT_MT;
    assign is_s   = is_cp1 && fmt == FMT_S;
    assign fs_v   = fpr_q[fs];
    assign ft_v   = fpr_q[ft];
    assign issue  = is_s && (funct == F_ADD || funct == F_SUB);

    assign data_from_cp1 = is_mf ? fs_v : 32'd0;
    assign cond          = cond_q;
    assign busy          = state_q != S_IDLE;
    assign done          = state_q == S_WRITE;

    // Signed-magnitude ordering; +0 and -0 compare equal.
    logic both_zero, f_eq, f_lt;

    always_comb begin
        both_zero = fs_v[30:0] == 31'd0 && ft_v[30:0] == 31'd0;
        f_eq      = both_zero || fs_v == ft_v;
        f_lt      = 1'b0;
        if (!both_zero) begin
            case ({fs_v[31], ft_v[31]})
                2'b10:   f_lt = 1'b1;
                2'b01:   f_lt = 1'b0;
                2'b00:   f_lt = fs_v[30:0] < ft_v[30:0];
                default: f_lt = fs_v[30:0] > ft_v[30:0];
            endcase
        end
    end

    logic [7:0]  ea, eb, diff;
    logic [23:0] mna, mnb;
    logic        swap;
    logic [24:0] sum;

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        fd_d    = fd_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        exp_d   = exp_q;
        cnt_d   = cnt_q;
        big_d   = big_q;
        ea      = opa_q[30:23];
        eb      = opb_q[30:23];
        mna     = (ea == 8'd0) ? 24'd0 : {1'b1, opa_q[22:0]};
        mnb     = (eb == 8'd0) ? 24'd0 : {1'b1, opb_q[22:0]};
        swap    = {eb, mnb} > {ea, mna};
        diff    = swap ? eb - ea : ea - eb;
        sum     = 25'd0;
        unique case (state_q)
            S_IDLE: begin
                if (issue) begin
                    opa_d   = fs_v;
                    opb_d   = {ft_v[31] ^ (funct == F_SUB), ft_v[30:0]};
                    fd_d    = fd;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                sa_d    = swap ? opb_q[31] : opa_q[31];
                sb_d    = swap ? opa_q[31] : opb_q[31];
                ma_d    = swap ? mnb : mna;
                mb_d    = swap ? mna : mnb;
                exp_d   = $signed({2'b00, swap ? eb : ea});
                big_d   = diff > AMAX8;
                cnt_d   = (diff > AMAX8) ? AMAXC : CW'(diff);
                state_d = (diff == 8'd0) ? S_ADD : S_ALIGN;
            end
            S_ALIGN: begin
                mb_d  = big_q ? 24'd0 : mb_q >> 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                sum = (sa_q == sb_q) ? {1'b0, ma_q} + {1'b0, mb_q}
                                     : {1'b0, ma_q} - {1'b0, mb_q};
                if (sum[24]) begin
                    ma_d  = sum[24:1];
                    exp_d = exp_q + 10'sd1;
                end else begin
                    ma_d = sum[23:0];
                end
                state_d = (ma_d != 24'd0 && !ma_d[23]) ? S_NORM : S_WRITE;
            end
            S_NORM: begin
                ma_d  = ma_q << 1;
                exp_d = exp_q - 10'sd1;
                if (ma_d[23]) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Underflow flushes to +0, overflow saturates to signed infinity.
    logic [31:0] res;

    always_comb begin
        res = {sa_q, exp_q[7:0], ma_q[22:0]};
        if (ma_q == 24'd0 || exp_q <= 10'sd0) begin
            res = 32'd0;
        end else if (exp_q >= 10'sd255) begin
            res = {sa_q, 8'hFF, 23'd0};
        end
    end

    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        idle, st_w;

    assign idle = state_q == S_IDLE;
    assign st_w = state_q == S_WRITE;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = fd;
        wr_data = fs_v;
        cond_d  = cond_q;
        unique case (1'b1)
            st_w: begin
                wr_en   = 1'b1;
                wr_addr = fd_q;
                wr_data = res;
            end
            idle && is_mt: begin
                wr_en   = 1'b1;
                wr_addr = fs;
                wr_data = data_to_cp1;
            end
            idle && is_s: begin
                case (funct)
                    F_MOV: wr_en = 1'b1;
                    F_NEG: begin
                        wr_en   = 1'b1;
                        wr_data = {~fs_v[31], fs_v[30:0]};
                    end
                    F_ABS: begin
                        wr_en   = 1'b1;
                        wr_data = {1'b0, fs_v[30:0]};
                    end
                    F_CEQ:   cond_d = f_eq;
                    F_CLT:   cond_d = f_lt;
                    F_CLE:   cond_d = f_lt | f_eq;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                fpr_q[i] <= 32'd0;
            end
        end else if (wr_en) begin
            fpr_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cond_q  <= 1'b0;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            fd_q    <= 5'd0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            ma_q    <= 24'd0;
            mb_q    <= 24'd0;
            exp_q   <= 10'sd0;
            cnt_q   <= '0;
            big_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cond_q  <= cond_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            fd_q    <= fd_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            exp_q   <= exp_d;
            cnt_q   <= cnt_d;
            big_q   <= big_d;
        end
    end

endmodule

// File: tb/tb_cp1_fpu.sv
// tb_cp1_fpu: scoreboard bench for cp1_fpu with directed cases and
// random instruction streams checked against a behavioural model.
module tb_cp1_fpu;
    localparam int AMAX = 26;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst = 32'd0;
    logic [31:0] data_to_cp1 = 32'd0;
    logic [31:0] data_from_cp1;
    logic        cond, busy, done;

    cp1_fpu #(.ALIGN_MAX(AMAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst         (inst),
        .data_to_cp1  (data_to_cp1),
        .data_from_cp1(data_from_cp1),
        .cond         (cond),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        cond;
        logic [31:0] rd;
    } exp_t;

    exp_t st_q[$];
    int   lat_q[$];
    int   checks = 0;
    int   failures = 0;

    logic [31:0] m_fpr [32];
    logic        m_cond;
    int          m_left;
    logic [4:0]  m_fd;
    logic [31:0] m_res;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint key(input logic [31:0] a);
        longint m;
        m = longint'(a[30:0]);
        return a[31] ? -m : m;
    endfunction

    // Real-number-style add of two floats with flush, truncation and saturation.
    function automatic logic [31:0] ref_addsub(input logic [31:0] a,
                                               input logic [31:0] b,
                                               output int lat);
        int ea, eb, ma, mb, d, al, s, e, n, t;
        logic sa, sb, ts;
        sa = a[31];
        sb = b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = (ea == 0) ? 0 : (1 << 23) + int'(a[22:0]);
        mb = (eb == 0) ? 0 : (1 << 23) + int'(b[22:0]);
        if (eb > ea || (eb == ea && mb > ma)) begin
            t = ea; ea = eb; eb = t;
            t = ma; ma = mb; mb = t;
            ts = sa; sa = sb; sb = ts;
        end
        d  = ea - eb;
        al = (d > AMAX) ? AMAX : d;
        mb = (d > AMAX) ? 0 : mb >> d;
        s  = (sa == sb) ? ma + mb : ma - mb;
        e  = ea;
        n  = 0;
        if (s >= (1 << 24)) begin
            s = s >> 1;
            e = e + 1;
        end
        while (s != 0 && s < (1 << 23)) begin
            s = s << 1;
            e = e - 1;
            n++;
        end
        lat = 3 + al + n;
        if (s == 0 || e <= 0) return 32'h0;
        if (e >= 255) return {sa, 8'hFF, 23'h0};
        return {sa, e[7:0], s[22:0]};
    endfunction

    function automatic logic [31:0] enc_mf(input logic [4:0] fs);
        return {6'h11, 5'd0, 5'd0, fs, 11'd0};
    endfunction

    function automatic logic [31:0] enc_mt(input logic [4:0] fs);
        return {6'h11, 5'd4, 5'd0, fs, 11'd0};
    endfunction

    function automatic logic [31:0] enc_s(input logic [5:0] fn, input logic [4:0] fd,
                                          input logic [4:0] fs, input logic [4:0] ft);
        return {6'h11, 5'd16, ft, fs, fd, fn};
    endfunction

    // One cycle: record what the DUT should show now, then advance the model.
    task automatic step(input logic [31:0] w, input logic [31:0] d);
        exp_t e;
        logic [4:0] fs, ft, fd;
        logic [5:0] fn;
        int lat;
        @(posedge clk);
        #1;
        inst = w;
        data_to_cp1 = d;
        fs = w[15:11];
        ft = w[20:16];
        fd = w[10:6];
        fn = w[5:0];
        e.busy = m_left > 0;
        e.done = m_left == 1;
        e.cond = m_cond;
        e.rd = (w[31:26] == 6'h11 && w[25:21] == 5'd0) ? m_fpr[fs] : 32'd0;
        st_q.push_back(e);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_fpr[m_fd] = m_res;
        end else if (w[31:26] == 6'h11) begin
            if (w[25:21] == 5'd4) begin
                m_fpr[fs] = d;
            end else if (w[25:21] == 5'd16) begin
                case (fn)
                    6'd6:  m_fpr[fd] = m_fpr[fs];
                    6'd7:  m_fpr[fd] = m_fpr[fs] ^ 32'h8000_0000;
                    6'd5:  m_fpr[fd] = m_fpr[fs] & 32'h7FFF_FFFF;
                    6'd50: m_cond = key(m_fpr[fs]) == key(m_fpr[ft]);
                    6'd60: m_cond = key(m_fpr[fs]) < key(m_fpr[ft]);
                    6'd62: m_cond = key(m_fpr[fs]) <= key(m_fpr[ft]);
                    6'd0, 6'd1: begin
                        m_res = ref_addsub(m_fpr[fs],
                                           m_fpr[ft] ^ ((fn == 6'd1) ? 32'h8000_0000 : 32'h0),
                                           lat);
                        m_left = lat;
                        m_fd = fd;
                        lat_q.push_back(lat);
                    end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(32'h0, 32'h0);
    endtask

    task automatic mt(input logic [4:0] fs, input logic [31:0] v);
        step(enc_mt(fs), v);
    endtask

    task automatic chk_rd(input logic [4:0] fs, input logic [31:0] v);
        exp_t e;
        step(enc_mf(fs), 32'h0);
        e = st_q.pop_back();
        e.rd = v;
        st_q.push_back(e);
    endtask

    task automatic chk_cond(input logic v);
        exp_t e;
        step(32'h0, 32'h0);
        e = st_q.pop_back();
        e.cond = v;
        st_q.push_back(e);
    endtask

    task automatic addop(input logic [4:0] fd, input logic [4:0] fs, input logic [4:0] ft,
                         input logic sub, input int lat);
        int l;
        step(enc_s(sub ? 6'd1 : 6'd0, fd, fs, ft), 32'h0);
        if (lat_q.size() > 0) begin
            l = lat_q.pop_back();
            lat_q.push_back(lat);
        end
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #2;
        st_q.delete();
        lat_q.delete();
        inst = enc_mf(5'd9);
        rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cond", 32'(cond), 32'd0);
        check("rst_rd", data_from_cp1, 32'd0);
        for (int i = 0; i < 32; i++) m_fpr[i] = 32'd0;
        m_cond = 1'b0;
        m_left = 0;
        @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    function automatic logic [31:0] rnd_fp();
        logic        s;
        logic [22:0] m;
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom);
        case ($urandom_range(0, 5))
            0: return s ? 32'h8000_0000 : 32'h0;
            1: return $urandom;
            2: return {s, 8'(124 + $urandom_range(0, 6)), m};
            3: return {s, 8'(248 + $urandom_range(0, 6)), m};
            4: return {s, 8'($urandom_range(0, 3)), m};
            default: return {s, 8'($urandom_range(90, 140)), 23'($urandom_range(0, 7))};
        endcase
    endfunction

    int bcnt = 0;

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            if (busy === 1'b1) bcnt++;
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                check("busy", 32'(busy), 32'(e.busy));
                check("done", 32'(done), 32'(e.done));
                check("cond", 32'(cond), 32'(e.cond));
                check("rd", data_from_cp1, e.rd);
            end
            if (done === 1'b1) begin
                if (lat_q.size() == 0) check("spurious_done", 32'd1, 32'd0);
                else check("latency", 32'(bcnt), 32'(lat_q.pop_front()));
                bcnt = 0;
            end
            if (busy !== 1'b1) bcnt = 0;
        end else begin
            bcnt = 0;
        end
    end

    initial begin
        logic [31:0] w;
        logic [4:0]  a, b, c;
        int          r;
        for (int i = 0; i < 32; i++) m_fpr[i] = 32'd0;
        m_cond = 1'b0;
        m_left = 0;
        inst = enc_mf(5'd3);
        #3;
        check("init_busy", 32'(busy), 32'd0);
        check("init_done", 32'(done), 32'd0);
        check("init_cond", 32'(cond), 32'd0);
        check("init_rd", data_from_cp1, 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;

        mt(5'd3, 32'h3F80_0000);
        chk_rd(5'd3, 32'h3F80_0000);
        step(32'h0000_1800, 32'h0);

        mt(5'd1, 32'h3F80_0000);
        mt(5'd2, 32'h4000_0000);
        addop(5'd4, 5'd1, 5'd2, 1'b0, 4);
        idle(4);
        chk_rd(5'd4, 32'h4040_0000);

        mt(5'd1, 32'h4040_0000);
        addop(5'd6, 5'd1, 5'd2, 1'b1, 4);
        idle(4);
        chk_rd(5'd6, 32'h3F80_0000);
        mt(5'd7, 32'h1234_5678);
        addop(5'd7, 5'd1, 5'd1, 1'b1, 3);
        idle(3);
        chk_rd(5'd7, 32'h0000_0000);

        mt(5'd8, 32'hBF80_0000);
        mt(5'd9, 32'h3F80_0000);
        step(enc_s(6'd60, 5'd0, 5'd8, 5'd9), 32'h0);
        chk_cond(1'b1);
        step(enc_s(6'd60, 5'd0, 5'd9, 5'd8), 32'h0);
        chk_cond(1'b0);
        mt(5'd10, 32'h0000_0000);
        mt(5'd11, 32'h8000_0000);
        step(enc_s(6'd50, 5'd0, 5'd10, 5'd11), 32'h0);
        chk_cond(1'b1);
        step(enc_s(6'd7, 5'd12, 5'd9, 5'd0), 32'h0);
        chk_rd(5'd12, 32'hBF80_0000);
        step(enc_s(6'd5, 5'd13, 5'd8, 5'd0), 32'h0);
        chk_rd(5'd13, 32'h3F80_0000);

        mt(5'd14, 32'h3300_0000);
        addop(5'd15, 5'd9, 5'd14, 1'b0, 28);
        idle(28);
        chk_rd(5'd15, 32'h3F80_0000);
        mt(5'd16, 32'h3080_0000);
        addop(5'd17, 5'd9, 5'd16, 1'b0, 29);
        idle(29);
        chk_rd(5'd17, 32'h3F80_0000);
        mt(5'd18, 32'h7F7F_FFFF);
        addop(5'd19, 5'd18, 5'd18, 1'b0, 3);
        idle(3);
        chk_rd(5'd19, 32'h7F80_0000);

        mt(5'd5, 32'h1111_1111);
        mt(5'd20, 32'h2222_2222);
        addop(5'd20, 5'd9, 5'd14, 1'b0, 28);
        mt(5'd5, 32'hDEAD_BEEF);
        chk_rd(5'd20, 32'h2222_2222);
        idle(26);
        chk_rd(5'd5, 32'h1111_1111);
        chk_rd(5'd20, 32'h3F80_0000);

        addop(5'd22, 5'd9, 5'd14, 1'b0, 28);
        idle(3);
        reset_mid();
        chk_rd(5'd22, 32'h0);
        chk_rd(5'd9, 32'h0);

        for (int k = 0; k < 1000; k++) begin
            r = $urandom_range(0, 99);
            a = 5'($urandom_range(0, 7));
            b = 5'($urandom_range(0, 7));
            c = 5'($urandom_range(0, 7));
            if (r < 22) mt(a, rnd_fp());
            else if (r < 40) step(enc_mf(a), 32'h0);
            else if (r < 55) step(enc_s(6'($urandom_range(0, 1)), a, b, c), 32'h0);
            else if (r < 62) step(enc_s(6'd6, a, b, c), 32'h0);
            else if (r < 67) step(enc_s(6'd7, a, b, c), 32'h0);
            else if (r < 72) step(enc_s(6'd5, a, b, c), 32'h0);
            else if (r < 76) step(enc_s(6'd50, a, b, c), 32'h0);
            else if (r < 79) step(enc_s(6'd60, a, b, c), 32'h0);
            else if (r < 82) step(enc_s(6'd62, a, b, c), 32'h0);
            else if (r < 88) begin
                w = $urandom;
                if (w[31:26] == 6'h11) w[31:26] = 6'h00;
                step(w, $urandom);
            end else if (r < 91) step(enc_s(6'(8 + $urandom_range(0, 7)), a, b, c), 32'h0);
            else if (r < 94) step({6'h11, 5'd17, c, b, a, 6'd0}, $urandom);
            else step(32'h0, $urandom);
        end

        idle(60);
        for (int i = 0; i < 8; i++) chk_rd(5'(i), m_fpr[i]);
        @(negedge clk);
        #1;
        check("pending_ops", 32'(lat_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cp1_fpu.md
Name: cp1_fpu

Overview:
- CP1 coprocessor at the far end of the CPU↔CP1 interface.
- Each cycle it consumes the CPU's fetched instruction word and GPR write data (`data_to_cp1`), and returns FPR read data (`data_from_cp1`).
- Holds 32×32-bit FP registers and a condition flag.
- Executes MIPS COP1 moves, single-cycle single-precision ops and a multi-cycle iterative `add.s`/`sub.s`.

Parameters:
- ALIGN_MAX, 26, maximum alignment shift; a larger exponent difference zeroes the smaller operand.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-low
- inst  input  32  CPU instruction word; one instruction per cycle, always valid
- data_to_cp1  input  32  GPR[rt] value from the CPU
- data_from_cp1  output  32  FPR[fs] for `mfc1`; 0 otherwise
- cond  output  1  FP condition flag
- busy  output  1  add/sub in progress
- done  output  1  one-cycle pulse on add/sub writeback

Behaviour:
- **Decode**
  - A CP1 instruction has `inst[31:26]`=6'b010001.
  - fmt=`inst[25:21]`, rt/ft=`inst[20:16]`, fs=`inst[15:11]`, fd=`inst[10:6]`, funct=`inst[5:0]`.
  - Non-CP1 words are ignored.
  - Undefined fmt/funct values are no-ops.
- **fmt 00000, mfc1:** `data_from_cp1` = FPR[fs], combinational, same cycle. `data_from_cp1`=0 for all other instructions.
- **fmt 00100, mtc1:** FPR[fs] <= `data_to_cp1` at the clock edge.
- **fmt 10000 (S), single-cycle ops, written at the edge:**
  - mov.s, funct 000110: FPR[fd]<=FPR[fs].
  - neg.s, funct 000111: FPR[fd]<=FPR[fs] with bit31 inverted.
  - abs.s, funct 000101: FPR[fd]<=FPR[fs] with bit31 cleared.
- **Compares (fmt S), update `cond` at the edge:**
  - c.eq.s, funct 110010: cond<=(fs==ft), with +0 == −0.
  - c.lt.s, funct 111100: cond<=(fs<ft).
  - c.le.s, funct 111110: cond<=(fs<=ft).
  - Ordering is signed-magnitude. NaN inputs are treated as ordinary bit patterns.
- **add.s (funct 000000) / sub.s (funct 000001), FSM IDLE→UNPACK→ALIGN→ADD→NORM→WRITE→IDLE:**
  - **IDLE:** on issue, latch fs/ft values (ft sign inverted for sub), fd, and go to UNPACK.
  - **UNPACK (1 cycle):**
    - Split into sign, exponent, 24-bit mantissa with hidden bit.
    - Exponent 0 is flushed to zero (mantissa 0).
    - Order operands so operand A has the larger magnitude.
    - d = expA − expB.
  - **ALIGN:** shift mantissa B right 1 bit/cycle, decrementing d. Exactly min(d,ALIGN_MAX) cycles; 0 cycles if d=0. If d>ALIGN_MAX, mantissa B becomes 0.
  - **ADD (1 cycle):**
    - Same signs: 25-bit sum. Different signs: A−B.
    - Result sign = sign of A.
    - If the sum carries into bit 24: shift right 1, exp+1.
  - **NORM:** while mantissa≠0 and bit23=0, shift left 1 and decrement exp, 1 cycle each. 0 cycles if already normalised.
  - **WRITE (1 cycle):**
    - Truncated result goes to FPR[fd]; `done`=1.
    - Zero mantissa or exp≤0 writes +0 (0x00000000).
    - exp≥255 writes ±inf (exp 255, mantissa 0).
  - Latency from issue edge to write edge = 3 + alignCycles + normCycles.
- **Timing of busy/done**
  - `busy`=1 from the cycle after issue through the WRITE cycle inclusive.
  - `done` is high only in WRITE.
- **Instructions while busy**
  - add/sub, mov/neg/abs, compares and mtc1 are dropped (no state change).
  - mfc1 still reads combinationally. Reading FPR[fd] returns the old value until the WRITE edge.
- **Simultaneous writes:** none are possible, because the FSM holds off other writers while busy.
- **Register file:** FPR[0] is a normal writable register.
- **Reset (rst low, async)**
  - All FPRs=0, cond=0, busy=0, done=0, FSM=IDLE.
  - `data_from_cp1` follows decode (0 unless mfc1, which reads 0).
  - Reset mid-operation aborts it with no write.

Test Plan:
- **mtc1/mfc1 round trip:** mtc1 rt-data 0x3F800000 to fs=3, then mfc1 fs=3 → `data_from_cp1`=0x3F800000. A non-CP1 word → 0.
- **add.s:**
  - Setup: FPR1=0x3F800000 (1.0), FPR2=0x40000000 (2.0).
  - Issue add.s fd=4, fs=1, ft=2.
  - `busy`=1 for 4 cycles; `done` pulses in the 4th.
  - FPR4=0x40400000; latency 4 edges.
- **sub.s cancellation:**
  - FPR1=0x40400000 (3.0), FPR2=0x40000000 (2.0); sub.s → 0x3F800000 with 1 NORM cycle.
  - sub.s FPR1−FPR1 → 0x00000000.
- **Compares and sign ops:**
  - c.lt.s with fs=−1.0 (0xBF800000), ft=1.0 → cond=1.
  - c.eq.s with +0 vs 0x80000000 → cond=1.
  - neg.s on 0x3F800000 → 0xBF800000.
  - abs.s on 0xBF800000 → 0x3F800000.
- **Alignment overflow and saturation:**
  - 1.0 + 0x33000000 (2^−25, d=25): 25 ALIGN cycles, result 0x3F800000.
  - d=30: 26 ALIGN cycles, result 0x3F800000.
  - 0x7F7FFFFF+0x7F7FFFFF → 0x7F800000.
- **Busy drop and reset abort:**
  - mtc1 to fs=5 issued while busy → FPR5 unchanged.
  - rst low mid-ALIGN → `busy`=0 immediately and FPR[fd] stays 0.
